// File: rtl/counter_mod.sv
// Modulo-MODULUS up/down counter with clamped parallel load, wrap or saturate at
// terminal, a combinational carry for cascading and a sticky overflow flag.
module counter_mod #(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 16,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             res,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             en,
    input  logic             up,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] TOP = WIDTH'(MODULUS - 1);

    logic             terminal;
    logic [WIDTH-1:0] q_next;
    logic             ovf_next;

    function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
        return (v > TOP) ? TOP : v;
    endfunction

    // Wrap or hold at the terminal value, otherwise a plain +/-1 step.
    function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] v,
                                              input logic dir,
                                              input logic at_term);
        if (at_term) begin
            if (SATURATE != 0)
                return v;
            return dir ? '0 : TOP;
        end
        return dir ? v + 1'b1 : v - 1'b1;
    endfunction

    always_comb begin
        terminal = up ? (q == TOP) : (q == '0);
    end

    // While res is high q is already zero and clr/load are ignored, so the
    // carry reflects only en and the direction.
    assign tc = en & terminal & (res | ~(clr | load));

    always_comb begin
        q_next   = q;
        ovf_next = ovf;
        if (clr) begin
            q_next   = '0;
            ovf_next = 1'b0;
        end else if (load) begin
            q_next = clamp_load(din);
        end else if (en) begin
            q_next = step(q, up, terminal);
            if (terminal)
                ovf_next = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            q   <= '0;
            ovf <= 1'b0;
        end else begin
            q   <= q_next;
            ovf <= ovf_next;
        end
    end

endmodule

// File: tb/tb_counter_mod.sv
// Scoreboard bench for counter_mod: wrap, saturate and a two-stage cascade are
// driven together and compared against an integer-arithmetic reference model.
module tb_counter_mod;

    localparam int M = 10;

    logic       clk = 1'b0;
    logic       res = 1'b1;
    logic       clr = 1'b0;
    logic       load = 1'b0;
    logic [3:0] din = '0;
    logic       en = 1'b0;
    logic       up = 1'b1;

    logic [3:0] q, q_s, q_lo, q_hi;
    logic       tc, tc_s, tc_lo, tc_hi;
    logic       ovf, ovf_s, ovf_lo, ovf_hi;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    counter_mod #(.WIDTH(4), .MODULUS(M), .SATURATE(0)) dut (
        .clk(clk), .res(res), .clr(clr), .load(load), .din(din),
        .en(en), .up(up), .q(q), .tc(tc), .ovf(ovf));

    counter_mod #(.WIDTH(4), .MODULUS(M), .SATURATE(1)) dut_sat (
        .clk(clk), .res(res), .clr(clr), .load(load), .din(din),
        .en(en), .up(up), .q(q_s), .tc(tc_s), .ovf(ovf_s));

    counter_mod #(.WIDTH(4), .MODULUS(M), .SATURATE(0)) dut_lo (
        .clk(clk), .res(res), .clr(clr), .load(1'b0), .din(4'd0),
        .en(en), .up(up), .q(q_lo), .tc(tc_lo), .ovf(ovf_lo));

    counter_mod #(.WIDTH(4), .MODULUS(M), .SATURATE(0)) dut_hi (
        .clk(clk), .res(res), .clr(clr), .load(1'b0), .din(4'd0),
        .en(tc_lo), .up(up), .q(q_hi), .tc(tc_hi), .ovf(ovf_hi));

    typedef struct {
        int tc, q, ovf;
        int tc_s, q_s, ovf_s;
        int tc_c, cval;
    } exp_t;

    exp_t sb[$];

    // Reference state: plain integers
    int mq = 0, movf = 0, mqs = 0, movfs = 0, cval = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
        end
    endtask

    // One clock of stimulus: drive on the falling edge, push the expected
    // same-cycle carry and the state after the following rising edge.
    task automatic cycle(input bit r, input bit c, input bit l, input int d,
                         input bit e, input bit u);
        exp_t x;
        int term, cterm, stepv, cstep, dv;
        @(negedge clk);
        res = r; clr = c; load = l; din = 4'(d); en = e; up = u;
        if (r) begin
            mq = 0; movf = 0; mqs = 0; movfs = 0; cval = 0;
        end
        term  = u ? M - 1 : 0;
        cterm = u ? M * M - 1 : 0;
        stepv = u ? 1 : M - 1;
        cstep = u ? 1 : M * M - 1;
        dv    = d & 15;
        x.tc   = (e && !c && !l && mq == term) ? 1 : 0;
        x.tc_s = (e && !c && !l && mqs == term) ? 1 : 0;
        x.tc_c = (e && !c && cval == cterm) ? 1 : 0;
        if (!r) begin
            if (c) begin
                mq = 0; movf = 0; mqs = 0; movfs = 0;
            end else if (l) begin
                mq  = (dv > M - 1) ? M - 1 : dv;
                mqs = mq;
            end else if (e) begin
                if (mq == term) movf = 1;
                mq = (mq + stepv) % M;
                if (mqs == term) movfs = 1;
                else mqs = (mqs + stepv) % M;
            end
            if (c) cval = 0;
            else if (e) cval = (cval + cstep) % (M * M);
        end
        x.q = mq; x.ovf = movf; x.q_s = mqs; x.ovf_s = movfs; x.cval = cval;
        sb.push_back(x);
        if (r) begin
            #1;
            chk("async_rst_q", 32'(q), 0);
            chk("async_rst_ovf", 32'(ovf), 0);
        end
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    // Monitor: carry sampled mid-low-phase, state just after the rising edge.
    initial begin
        exp_t x;
        logic [31:0] s_tc, s_tcs, s_tcc;
        forever begin
            @(negedge clk);
            #3;
            s_tc = 32'(tc); s_tcs = 32'(tc_s); s_tcc = 32'(tc_hi);
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                x = sb.pop_front();
                chk("tc", s_tc, x.tc);
                chk("q", 32'(q), x.q);
                chk("ovf", 32'(ovf), x.ovf);
                chk("tc_sat", s_tcs, x.tc_s);
                chk("q_sat", 32'(q_s), x.q_s);
                chk("ovf_sat", 32'(ovf_s), x.ovf_s);
                chk("tc_cascade", s_tcc, x.tc_c);
                chk("q_cascade", 32'(q_hi) * 10 + 32'(q_lo), x.cval);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        cycle(1, 0, 0, 0, 0, 1);
        cycle(1, 0, 0, 0, 1, 1);

        // Up wrap over 12 edges
        for (int i = 0; i < 12; i++) cycle(0, 0, 0, 0, 1, 1);
        settle();
        chk("upwrap_q", 32'(q), 2);
        chk("upwrap_ovf", 32'(ovf), 1);
        chk("upwrap_sat_q", 32'(q_s), 9);

        // Down from 0: wrap to 9, saturating copy holds 0
        cycle(0, 1, 0, 0, 0, 1);
        cycle(0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 1, 0);
        settle();
        chk("down_q", 32'(q), 7);
        chk("down_sat_q", 32'(q_s), 0);
        chk("down_sat_ovf", 32'(ovf_s), 1);

        // Load clamp, then clr beats load
        cycle(0, 0, 1, 13, 1, 1);
        settle();
        chk("clamp_q", 32'(q), 9);
        cycle(0, 1, 1, 5, 1, 1);
        settle();
        chk("clr_pri_q", 32'(q), 0);
        chk("clr_pri_ovf", 32'(ovf), 0);

        // Direction flip at 9
        cycle(0, 0, 1, 9, 0, 1);
        cycle(0, 0, 0, 0, 1, 0);
        settle();
        chk("flip_q", 32'(q), 8);

        // Async reset mid-count with ovf set, then resume
        cycle(1, 0, 0, 0, 0, 1);
        for (int i = 0; i < 15; i++) cycle(0, 0, 0, 0, 1, 1);
        settle();
        chk("pre_rst_q", 32'(q), 5);
        chk("pre_rst_ovf", 32'(ovf), 1);
        cycle(1, 0, 0, 0, 1, 1);
        cycle(0, 0, 0, 0, 1, 1);
        settle();
        chk("resume_q", 32'(q), 1);

        // Cascade: 123 edges gives 2,3
        cycle(1, 0, 0, 0, 0, 1);
        for (int i = 0; i < 123; i++) cycle(0, 0, 0, 0, 1, 1);
        settle();
        chk("cascade_hi", 32'(q_hi), 2);
        chk("cascade_lo", 32'(q_lo), 3);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            bit r, c, l, e, u;
            r = ($urandom % 50) == 0;
            c = !r && ($urandom % 16) == 0;
            l = !r && ($urandom % 8) == 0;
            e = ($urandom % 4) != 0;
            u = ($urandom % 3) != 0;
            cycle(r, c, l, int'($urandom % 16), e, u);
        end

        cycle(0, 0, 0, 0, 0, 1);
        repeat (3) settle();
        chk("scoreboard_drained", 32'(sb.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/counter_mod.md
COUNTER_MOD -- requirements
Module: counter_mod

Interface
- REQ-001: Parameter WIDTH SHALL default to 4 and set the count register width in bits.
- REQ-002: Parameter MODULUS SHALL default to 16 and set the count range 0..MODULUS-1; legal range is 2 <= MODULUS <= 2**WIDTH.
- REQ-003: Parameter SATURATE SHALL default to 0; 0 selects wrap at terminal, 1 selects hold at terminal.
- REQ-004: clk  input  1  sole clock; all state SHALL update on the rising edge.
- REQ-005: res  input  1  reset, asynchronous and active-high.
- REQ-006: clr  input  1  synchronous clear of count and overflow flag.
- REQ-007: load  input  1  synchronous parallel load of din.
- REQ-008: din  input  WIDTH  load value.
- REQ-009: en  input  1  count enable, the cascade input from a lower stage.
- REQ-010: up  input  1  direction; 1 counts up, 0 counts down.
- REQ-011: q  output  WIDTH  registered count value.
- REQ-012: tc  output  1  combinational terminal-count/carry, the cascade output to a higher stage's en.
- REQ-013: ovf  output  1  registered sticky overflow/underflow flag.

Function
- REQ-014: Per-edge priority SHALL be res > clr > load > en; with none active, q and ovf SHALL hold.
- REQ-015: clr=1 SHALL set q=0 and ovf=0 on the next edge, regardless of load, en and up.
- REQ-016: load=1 (clr=0) SHALL set q=din when din <= MODULUS-1, otherwise q=MODULUS-1 (clamp); ovf SHALL be unchanged.
- REQ-017: en=1 with up=1 and q < MODULUS-1 SHALL set q=q+1; en=1 with up=0 and q > 0 SHALL set q=q-1.
- REQ-018: Terminal state SHALL be q=MODULUS-1 when up=1 and q=0 when up=0.
- REQ-019: en=1 at terminal with SATURATE=0 SHALL wrap: up gives 0, down gives MODULUS-1.
- REQ-020: en=1 at terminal with SATURATE=1 SHALL hold q.
- REQ-021: tc SHALL equal en & ~clr & ~load & terminal, with zero cycles of latency (same cycle as the inputs).
- REQ-022: ovf SHALL be set to 1 on any edge where tc=1 and SHALL stay 1 until clr or res.
- REQ-023: A direction change SHALL take effect on the same edge; terminal evaluation SHALL use the current up.
- REQ-024: Arithmetic SHALL be modulo-MODULUS in the WIDTH-bit domain; q SHALL never exceed MODULUS-1 once reset.
- REQ-025: A chain of N instances with tc(i) wired to en(i+1), shared clk/res/up, SHALL behave as a single modulo MODULUS**N counter with no added latency.

Reset
- REQ-026: res=1 SHALL force q=0 and ovf=0 immediately, without waiting for a clk edge.
- REQ-027: While res=1, all synchronous inputs SHALL be ignored and tc SHALL reflect q=0 under the current en/up.
- REQ-028: Deassertion of res SHALL allow the first update on the next rising clk edge; a reset asserted mid-count SHALL discard the count with no partial state retained.

Verification (WIDTH=4, MODULUS=10 unless stated)
- REQ-029: Up wrap: reset, en=1, up=1 for 12 edges -> q = 1..9,0,1,2; tc=1 only while q=9; ovf=1 from the 10th edge onward.
- REQ-030: Down wrap and saturate: load 0 then en=1, up=0 -> q=9 next edge; with SATURATE=1, q stays 0, tc=1 each cycle, and ovf sets.
- REQ-031: Load clamp and priority: din=13, load=1, en=1 -> q=9 with ovf unchanged; clr=1, load=1 on the same edge -> q=0, ovf=0.
- REQ-032: Async reset: drive res=1 between edges while q=5, ovf=1 -> q=0 and ovf=0 before the next edge; the count resumes from 1 on the first edge after release.
- REQ-033: Cascade: two instances, MODULUS=10, en=1 for 123 edges -> {q_hi,q_lo} = 2,3; the high stage increments only on edges where the low stage tc=1.
- REQ-034: Direction flip at terminal: q=9, up toggles to 0 with en=1 -> q=8 and tc=0 in that cycle.
